fgio_seq_ctrl: RTL

FGIO_SEQ_CTRL -- requirements
Module: fgio_seq_ctrl

---
 rtl/fgio_pkg.sv | 25 ++
 rtl/fgio_idx_cnt.sv | 29 ++
 rtl/fgio_seq_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fgio_pkg.sv
// Shared types and constants for the gated-cell sequence controller.
package fgio_pkg;

  localparam int VEC_LEN = 100;
  localparam int DATA_W  = 32;
  localparam int IDX_W   = 7;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_X,
    GATE,
    CELL,
    HOUT,
    DONE
  } state_e;

  // Order matches the order the shared non-linear unit walks the gates.
  typedef enum logic [1:0] {
    GATE_F,
    GATE_G,
    GATE_I,
    GATE_O
  } gate_e;

endpackage

// File: rtl/fgio_idx_cnt.sv
// Element index counter: counts 0..N-1 while enabled and wraps back to 0.
module fgio_idx_cnt
  import fgio_pkg::*;
#(
  parameter int N = 100,
  parameter int W = IDX_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  // Asserted in the cycle whose edge takes the count from N-1 back to 0.
  assign wrap = en && !clr && (cnt == W'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fgio_seq_ctrl.sv
// Sequencer for one gated recurrent cell: gate activations, cell update and
// hidden-state output per time step, repeated seq_len times.
//
// state  | meaning
// IDLE   | waiting for start
// WAIT_X | x_ready high, waiting for the gate pre-activation vector
// GATE   | act_en each cycle, walking idx through F, G, I, O gates
// CELL   | c_we each cycle, writing c_next for every element
// HOUT   | h_valid each cycle, idx advances on h_ready
// DONE   | one-cycle done pulse, then IDLE
module fgio_seq_ctrl
  import fgio_pkg::*;
#(
  parameter int VEC_LEN = fgio_pkg::VEC_LEN,
  parameter int STEP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [STEP_W-1:0] seq_len,
  input  logic              abort,
  input  logic              x_valid,
  output logic              x_ready,
  output logic              act_en,
  output logic [1:0]        act_sel,
  output logic [6:0]        idx,
  output logic              c_we,
  output logic              c_clr,
  output logic              h_valid,
  input  logic              h_ready,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] step_cnt
);

  state_e            state;
  gate_e             sel;
  logic [STEP_W-1:0] len;
  logic              cnt_en;
  logic              cnt_clr;
  logic              wrap;
  logic              last_step;

  // idx only runs in the three element-walking states; everywhere else it is held at 0.
  assign cnt_en    = (state == GATE) || (state == CELL) || ((state == HOUT) && h_ready);
  assign cnt_clr   = abort || !((state == GATE) || (state == CELL) || (state == HOUT));
  assign last_step = (step_cnt + 1'b1) == len;
  assign act_sel   = sel;

  fgio_idx_cnt #(
    .N (VEC_LEN),
    .W (7)
  ) u_idx_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .cnt   (idx),
    .wrap  (wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= GATE_F;
      step_cnt <= '0;
      len      <= '0;
      x_ready  <= 1'b0;
      act_en   <= 1'b0;
      c_we     <= 1'b0;
      c_clr    <= 1'b0;
      h_valid  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      c_clr <= 1'b0;
      done  <= 1'b0;
      // Abort outranks every transition, including the final HOUT handshake.
      if (abort && (state != IDLE)) begin
        state   <= IDLE;
        sel     <= GATE_F;
        x_ready <= 1'b0;
        act_en  <= 1'b0;
        c_we    <= 1'b0;
        h_valid <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              step_cnt <= '0;
              len      <= seq_len;
              busy     <= 1'b1;
              if (seq_len == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state   <= WAIT_X;
                c_clr   <= 1'b1;
                x_ready <= 1'b1;
              end
            end
          end
          WAIT_X: begin
            if (x_valid) begin
              state   <= GATE;
              x_ready <= 1'b0;
              act_en  <= 1'b1;
              sel     <= GATE_F;
            end
          end
          GATE: begin
            if (wrap) begin
              sel <= gate_e'(sel + 2'd1);
              if (sel == GATE_O) begin
                state  <= CELL;
                act_en <= 1'b0;
                c_we   <= 1'b1;
              end
            end
          end
          CELL: begin
            if (wrap) begin
              state   <= HOUT;
              c_we    <= 1'b0;
              h_valid <= 1'b1;
            end
          end
          HOUT: begin
            if (wrap) begin
              h_valid <= 1'b0;
              if (last_step) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state    <= WAIT_X;
                step_cnt <= step_cnt + 1'b1;
                x_ready  <= 1'b1;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
